key_event_ctrl: RTL

- Multi-channel key event controller that sits downstream of the per-button debouncers.
- Turns each debounced level into PRESS, RELEASE, LONG and REPEAT events, timed from one shared millisecond prescaler.
- Shares a single event output port between all channels through a round-robin valid/ready arbiter feeding the UI/CPU side.

---
 rtl/key_event_pkg.sv | 20 ++
 rtl/key_event_chan.sv | 123 ++++++++++++
 rtl/key_event_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event controller: event codes, channel
// state encoding and the channel-index width helper.
package key_event_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_REPT = 2'd2
  } chan_state_t;

  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: press/long/repeat state machine, ms counter, a one-deep
// pending event register and a sticky overrun flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | key up, waiting for a press
//   ST_DOWN | key held, counting ms ticks towards LONG
//   ST_REPT | LONG already reported, counting ms ticks between REPEATs
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       level,
  input  logic       accept,
  input  logic       overrun_clr,
  output logic       pend_v,
  output logic [1:0] pend_code,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_TC  = (REPEAT_MS == 0) ? '0 : CNT_W'(REPEAT_MS - 1);
  localparam bit               REP_EN  = (REPEAT_MS != 0);

  chan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             raise;
  logic [1:0]       raise_code;

  // Release is checked before any timer expiry so it always wins.
  always_comb begin
    raise      = 1'b0;
    raise_code = EV_PRESS;
    case (state)
      ST_IDLE: begin
        if (level) begin
          raise      = 1'b1;
          raise_code = EV_PRESS;
        end
      end
      ST_DOWN: begin
        if (!level) begin
          raise      = 1'b1;
          raise_code = EV_RELEASE;
        end else if (tick && cnt == LONG_TC) begin
          raise      = 1'b1;
          raise_code = EV_LONG;
        end
      end
      ST_REPT: begin
        if (!level) begin
          raise      = 1'b1;
          raise_code = EV_RELEASE;
        end else if (tick && REP_EN && cnt == REP_TC) begin
          raise      = 1'b1;
          raise_code = EV_REPEAT;
        end
      end
      default: begin
        raise      = 1'b0;
        raise_code = EV_PRESS;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend_v    <= 1'b0;
      pend_code <= EV_PRESS;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (level) begin
            state <= ST_DOWN;
            cnt   <= '0;
          end
        end
        ST_DOWN: begin
          if (!level) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (cnt == LONG_TC) begin
              state <= ST_REPT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_REPT: begin
          if (!level) begin
            state <= ST_IDLE;
          end else if (tick && REP_EN) begin
            if (cnt == REP_TC) cnt <= '0;
            else               cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // An accept in the same cycle frees the slot for the new event.
      if (raise && (!pend_v || accept)) begin
        pend_v    <= 1'b1;
        pend_code <= raise_code;
      end else if (accept) begin
        pend_v <= 1'b0;
      end

      if (raise && pend_v && !accept) overrun <= 1'b1;
      else if (overrun_clr)           overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller top: shared ms prescaler, N_CH key channels and a
// round-robin valid/ready arbiter onto a single event port.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           debounced,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [chan_w(N_CH)-1:0]   ev_chan,
  output logic [1:0]                ev_code,
  output logic [N_CH-1:0]           overrun,
  input  logic                      overrun_clr
);

  localparam int              CW     = chan_w(N_CH);
  localparam int              PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_TC = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   LAST_CH = CW'(N_CH - 1);

  logic [PW-1:0]         pre_cnt;
  logic                  tick;
  logic [N_CH-1:0]       pend_v;
  logic [N_CH-1:0][1:0]  pend_code;
  logic [N_CH-1:0]       accept;
  logic [CW-1:0]         rr_ptr;
  logic [CW-1:0]         rr_sel;
  logic [CW-1:0]         lock_sel;
  logic [CW-1:0]         sel;
  logic                  rr_hit;
  logic                  lock;
  int                    idx;

  assign tick = (pre_cnt == PRE_TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    key_event_chan #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .level      (debounced[g]),
      .accept     (accept[g]),
      .overrun_clr(overrun_clr),
      .pend_v     (pend_v[g]),
      .pend_code  (pend_code[g]),
      .overrun    (overrun[g])
    );
  end

  // First pending channel at or after the pointer, wrapping.
  always_comb begin
    rr_sel = '0;
    rr_hit = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_ptr) + k) % N_CH;
      if (!rr_hit && pend_v[idx]) begin
        rr_hit = 1'b1;
        rr_sel = CW'(idx);
      end
    end
  end

  assign sel      = lock ? lock_sel : rr_sel;
  assign ev_valid = |pend_v;
  assign ev_chan  = ev_valid ? sel : '0;
  assign ev_code  = ev_valid ? pend_code[sel] : EV_PRESS;

  always_comb begin
    accept = '0;
    if (ev_valid && ev_ready) accept[sel] = 1'b1;
  end

  // A stalled offer is frozen so ev_chan/ev_code hold until the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock     <= 1'b0;
      lock_sel <= '0;
      rr_ptr   <= '0;
    end else if (ev_valid && ev_ready) begin
      lock   <= 1'b0;
      rr_ptr <= (sel == LAST_CH) ? '0 : sel + 1'b1;
    end else if (ev_valid && !lock) begin
      lock     <= 1'b1;
      lock_sel <= sel;
    end
  end

endmodule
